// File: rtl/bus_sequencer_pkg.sv
// Shared types for the bus sequencer: region decode and cycle state.
// Optional IO timeout is enabled by defining BUS_TIMEOUT_EN.
package bus_sequencer_pkg;

  typedef enum logic [1:0] {
    BR_ROM  = 2'b00,
    BR_RAM  = 2'b01,
    BR_IO   = 2'b10,
    BR_NONE = 2'b11
  } t_bus_region;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_ACCESS,
    BS_COMPLETE,
    BS_ERROR
  } t_bus_state;

  localparam int CNT_W = 8;

endpackage

// File: rtl/bus_sequencer_if.sv
// Request side (from businterface) and memory side of the sequencer.
// master = sequencer view, slave = requester/device view.
interface bus_sequencer_if;
  logic [29:0] req_address;
  logic [31:0] req_data_out;
  logic [3:0]  req_data_strobes;
  logic        req_read;
  logic        req_write;
  logic        req_align_error;
  logic [31:0] req_data_in;
  logic        req_ready;
  logic        req_bus_error;
  logic [29:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_strobes;
  logic        mem_read;
  logic        mem_write;
  logic        mem_rom_select;
  logic        mem_ram_select;
  logic        mem_io_select;
  logic        io_ack;

  modport master (
    input  req_address, req_data_out, req_data_strobes,
    input  req_read, req_write, req_align_error,
    output req_data_in, req_ready, req_bus_error,
    output mem_address, mem_data_out, mem_strobes,
    output mem_read, mem_write,
    output mem_rom_select, mem_ram_select, mem_io_select,
    input  mem_data_in, io_ack
  );

  modport slave (
    output req_address, req_data_out, req_data_strobes,
    output req_read, req_write, req_align_error,
    input  req_data_in, req_ready, req_bus_error,
    input  mem_address, mem_data_out, mem_strobes,
    input  mem_read, mem_write,
    input  mem_rom_select, mem_ram_select, mem_io_select,
    output mem_data_in, io_ack
  );
endinterface

// File: rtl/bus_sequencer_decoder.sv
// Region decode from the top two byte-address bits.
module bus_address_decoder
  import bus_sequencer_pkg::*;
(
  input  logic [1:0]  addr_hi,
  output t_bus_region region
);
  assign region = t_bus_region'(addr_hi);
endmodule

// File: rtl/bus_sequencer.sv
// Timed bus cycles with wait states for ROM/RAM/IO behind businterface.
// Define BUS_TIMEOUT_EN to abort IO cycles after TIMEOUT_CYCLES without io_ack.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int WAIT_ROM       = 1,
  parameter int WAIT_RAM       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clock,
  input logic             reset_n,
  bus_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] ROM_LD = CNT_W'(WAIT_ROM);
  localparam logic [CNT_W-1:0] RAM_LD = CNT_W'(WAIT_RAM);
`ifdef BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] IO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] IO_LD  = '0;
`endif

  t_bus_state       state_q, state_d;
  t_bus_region      region, region_q;
  logic [29:0]      addr_q;
  logic [31:0]      data_q;
  logic [31:0]      rdata_q;
  logic [3:0]       strb_q;
  logic             write_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch, capture, req_err, acc;

  bus_address_decoder u_dec (
    .addr_hi (bus.req_address[29:28]),
    .region  (region)
  );

  assign req_err = bus.req_align_error
                 || (region == BR_NONE)
                 || (region == BR_ROM && bus.req_write)
                 || (bus.req_read && bus.req_write);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      BS_IDLE: begin
        if (bus.req_read || bus.req_write) begin
          latch = 1'b1;
          if (req_err) begin
            state_d = BS_ERROR;
          end else begin
            state_d = BS_ACCESS;
            unique case (1'b1)
              region == BR_ROM: cnt_d = ROM_LD;
              region == BR_RAM: cnt_d = RAM_LD;
              default:          cnt_d = IO_LD;
            endcase
          end
        end
      end
      BS_ACCESS: begin
        if (region_q == BR_IO) begin
          if (bus.io_ack) begin
            state_d = BS_COMPLETE;
            capture = !write_q;
          end
`ifdef BUS_TIMEOUT_EN
          else if (cnt_q == '0) begin
            state_d = BS_ERROR;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`endif
        end else if (cnt_q == '0) begin
          state_d = BS_COMPLETE;
          capture = !write_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = BS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= BS_IDLE;
      region_q <= BR_ROM;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      write_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        region_q <= region;
        addr_q   <= bus.req_address;
        data_q   <= bus.req_data_out;
        strb_q   <= bus.req_data_strobes;
        write_q  <= bus.req_write;
      end
      if (capture) rdata_q <= bus.mem_data_in;
    end
  end

  assign acc = (state_q == BS_ACCESS);

  assign bus.mem_address    = addr_q;
  assign bus.mem_data_out   = data_q;
  assign bus.mem_strobes    = acc ? strb_q : 4'b0000;
  assign bus.mem_read       = acc && !write_q;
  assign bus.mem_write      = acc && write_q;
  assign bus.mem_rom_select = acc && (region_q == BR_ROM);
  assign bus.mem_ram_select = acc && (region_q == BR_RAM);
  assign bus.mem_io_select  = acc && (region_q == BR_IO);
  assign bus.req_data_in    = rdata_q;
  assign bus.req_ready      = (state_q == BS_COMPLETE);
  assign bus.req_bus_error  = (state_q == BS_ERROR);

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer (WAIT_ROM=1, WAIT_RAM=0, TIMEOUT_CYCLES=8).
// Covers both builds of BUS_TIMEOUT_EN.
module tb_bus_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_sequencer_if bus ();

  bus_sequencer #(
    .WAIT_ROM       (1),
    .WAIT_RAM       (0),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.req_align_error = 1'b0;
  endtask

  initial begin
    idle_req();
    bus.req_address      = '0;
    bus.req_data_out     = '0;
    bus.req_data_strobes = '0;
    bus.mem_data_in      = '0;
    bus.io_ack           = 1'b0;

    step(); step();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_err", 32'(bus.req_bus_error), 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_sel", {29'd0, bus.mem_rom_select,
        bus.mem_ram_select, bus.mem_io_select}, 32'd0);
    chk("rst_rdata", bus.req_data_in, 32'd0);
    rst_n = 1'b1;
    step();

    // RAM read 0x4000_0010, zero wait states
    bus.req_address = 30'h1000_0004;
    bus.mem_data_in = 32'h1234_5678;
    bus.req_read    = 1'b1;
    step();
    chk("ram_rd_sel", 32'(bus.mem_ram_select), 32'd1);
    chk("ram_rd_mrd", 32'(bus.mem_read), 32'd1);
    chk("ram_rd_addr", 32'(bus.mem_address), 32'h1000_0004);
    chk("ram_rd_rdy0", 32'(bus.req_ready), 32'd0);
    step();
    chk("ram_rd_rdy", 32'(bus.req_ready), 32'd1);
    chk("ram_rd_sel0", 32'(bus.mem_ram_select), 32'd0);
    chk("ram_rd_data", bus.req_data_in, 32'h1234_5678);
    idle_req();
    step();
    chk("ram_rd_pulse", 32'(bus.req_ready), 32'd0);

    // ROM write 0x0000_0004 is refused
    bus.req_address  = 30'h000_0001;
    bus.req_data_out = 32'h5555_aaaa;
    bus.req_write    = 1'b1;
    step();
    chk("rom_wr_err", 32'(bus.req_bus_error), 32'd1);
    chk("rom_wr_sel", 32'(bus.mem_rom_select), 32'd0);
    chk("rom_wr_mwr", 32'(bus.mem_write), 32'd0);
    idle_req();
    step();
    chk("rom_wr_err0", 32'(bus.req_bus_error), 32'd0);
    chk("rom_wr_mwr0", 32'(bus.mem_write), 32'd0);

    // RAM write with partial strobes
    bus.req_address      = 30'h1000_0008;
    bus.req_data_out     = 32'hffff_abcd;
    bus.req_data_strobes = 4'b0011;
    bus.mem_data_in      = 32'hdead_beef;
    bus.req_write        = 1'b1;
    step();
    chk("ram_wr_mwr", 32'(bus.mem_write), 32'd1);
    chk("ram_wr_strb", 32'(bus.mem_strobes), 32'h3);
    chk("ram_wr_data", bus.mem_data_out, 32'hffff_abcd);
    chk("ram_wr_mrd", 32'(bus.mem_read), 32'd0);
    step();
    chk("ram_wr_rdy", 32'(bus.req_ready), 32'd1);
    chk("ram_wr_strb0", 32'(bus.mem_strobes), 32'h0);
    chk("ram_wr_rdata", bus.req_data_in, 32'h1234_5678);
    idle_req();
    step();
    chk("ram_wr_hold", bus.mem_data_out, 32'hffff_abcd);

    // ROM read with one wait state
    bus.req_address = 30'h000_0002;
    bus.mem_data_in = 32'hcafe_f00d;
    bus.req_read    = 1'b1;
    step();
    chk("rom_rd_sel1", 32'(bus.mem_rom_select), 32'd1);
    step();
    chk("rom_rd_sel2", 32'(bus.mem_rom_select), 32'd1);
    chk("rom_rd_rdy0", 32'(bus.req_ready), 32'd0);
    step();
    chk("rom_rd_rdy", 32'(bus.req_ready), 32'd1);
    chk("rom_rd_data", bus.req_data_in, 32'hcafe_f00d);
    idle_req();
    step();

    // IO read 0x8000_0000, ack in the fifth access cycle
    bus.req_address = 30'h2000_0000;
    bus.mem_data_in = 32'h0bad_f00d;
    bus.req_read    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("io_sel_%0d", i), 32'(bus.mem_io_select), 32'd1);
      chk($sformatf("io_rdy_%0d", i), 32'(bus.req_ready), 32'd0);
      if (i == 4) bus.io_ack = 1'b1;
    end
    step();
    chk("io_rdy", 32'(bus.req_ready), 32'd1);
    chk("io_sel0", 32'(bus.mem_io_select), 32'd0);
    chk("io_data", bus.req_data_in, 32'h0bad_f00d);
    bus.io_ack = 1'b0;
    idle_req();
    step();

    // unmapped region
    bus.req_address = 30'h3000_0000;
    bus.req_read    = 1'b1;
    step();
    chk("unmap_err", 32'(bus.req_bus_error), 32'd1);
    idle_req();
    step();

    // misaligned RAM read
    bus.req_address     = 30'h1000_0000;
    bus.req_align_error = 1'b1;
    bus.req_read        = 1'b1;
    step();
    chk("align_err", 32'(bus.req_bus_error), 32'd1);
    chk("align_sel", 32'(bus.mem_ram_select), 32'd0);
    idle_req();
    step();

    // read and write together
    bus.req_read  = 1'b1;
    bus.req_write = 1'b1;
    step();
    chk("rdwr_err", 32'(bus.req_bus_error), 32'd1);
    idle_req();
    step();
    chk("rdwr_err0", 32'(bus.req_bus_error), 32'd0);

`ifdef BUS_TIMEOUT_EN
    // IO read never acknowledged
    bus.req_address = 30'h2000_0001;
    bus.req_read    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("to_sel_%0d", i), 32'(bus.mem_io_select), 32'd1);
    end
    step();
    chk("to_err", 32'(bus.req_bus_error), 32'd1);
    chk("to_sel0", 32'(bus.mem_io_select), 32'd0);
    idle_req();
    bus.io_ack = 1'b1;
    step();
    chk("late_ack_rdy", 32'(bus.req_ready), 32'd0);
    chk("late_ack_sel", 32'(bus.mem_io_select), 32'd0);
    bus.io_ack = 1'b0;
    step();
`endif

    // IO read without ack, then asynchronous reset mid-access
    bus.req_address = 30'h2000_0002;
    bus.req_read    = 1'b1;
    step();
    chk("hang_sel", 32'(bus.mem_io_select), 32'd1);
`ifndef BUS_TIMEOUT_EN
    repeat (300) step();
    chk("hang_sel300", 32'(bus.mem_io_select), 32'd1);
    chk("hang_mrd300", 32'(bus.mem_read), 32'd1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(bus.mem_io_select), 32'd0);
    chk("arst_mrd", 32'(bus.mem_read), 32'd0);
    chk("arst_addr", 32'(bus.mem_address), 32'd0);
    chk("arst_rdata", bus.req_data_in, 32'd0);
    chk("arst_dout", bus.mem_data_out, 32'd0);
    idle_req();
    step();
    chk("arst_rdy", 32'(bus.req_ready), 32'd0);
    chk("arst_err", 32'(bus.req_bus_error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
